// File: rtl/mig_seq_eval.sv
// mig_seq_eval: loadable majority-inverter-graph evaluator, one MAJ3 gate per clock under valid/ready.
//   clk, rst              clock, synchronous active-high reset
//   cfg_we/addr/data      gate-table (addr < MAX_GATES) or control-word (addr == MAX_GATES) write
//   cfg_ready             writes accepted only while idle
//   in_valid/in_ready/x   input vector handshake
//   out_valid/out_ready   result handshake; y and out_err hold while out_valid is high
//   y, out_err            function value, bad-reference flag for this evaluation
module mig_seq_eval #(
    parameter int NUM_IN    = 4,
    parameter int MAX_GATES = 8
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             cfg_we,
    input  logic [$clog2(MAX_GATES+1)-1:0]                   cfg_addr,
    input  logic [3*($clog2(1+NUM_IN+MAX_GATES)+1)-1:0]      cfg_data,
    output logic                                             cfg_ready,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [NUM_IN-1:0]                                x,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic                                             y,
    output logic                                             out_err
);
    localparam int SW = $clog2(1 + NUM_IN + MAX_GATES);
    localparam int AW = $clog2(MAX_GATES + 1);
    localparam int GW = $clog2(MAX_GATES);
    localparam int E  = SW + 1;
    localparam int NS = 1 + NUM_IN + MAX_GATES;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t            state_q, state_d;
    logic [3*E-1:0]    tbl_q [MAX_GATES];
    logic [3*E-1:0]    tbl_d [MAX_GATES];
    logic [AW-1:0]     num_q, num_d, num_wr, num_eff;
    logic              inv_q, inv_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [NUM_IN-1:0] x_q, x_d;
    logic [MAX_GATES-1:0] gv_q, gv_d;
    logic [GW-1:0]     g_q, g_d;
    logic              y_q, y_d, err_q, err_d, ov_q, ov_d;
    logic [NS-1:0]     sig;
    logic [3*E-1:0]    ent;
    logic [2:0]        op, bad;
    logic [SW:0]       gate_lim, out_lim;
    logic              maj, sel_bad, sel_val, wr_gate, wr_ctrl, last;

    // Flat signal space: const 0, then inputs, then gate outputs.
    assign sig      = {gv_q, x_q, 1'b0};
    assign wr_gate  = cfg_we && cfg_ready && (cfg_addr < AW'(MAX_GATES));
    assign wr_ctrl  = cfg_we && cfg_ready && (cfg_addr == AW'(MAX_GATES));
    assign num_wr   = (cfg_data[E +: AW] > AW'(MAX_GATES)) ? AW'(MAX_GATES) : cfg_data[E +: AW];
    // A control write in the accepting cycle must steer the EVAL/DONE choice.
    assign num_eff  = wr_ctrl ? num_wr : num_q;
    assign ent      = tbl_q[g_q];
    // Gate g may only read indices below its own slot; anything else is a bad reference.
    assign gate_lim = E'(NUM_IN + 1) + E'(g_q);
    assign out_lim  = E'(NUM_IN + 1) + E'(num_q);
    assign last     = AW'(g_q) == num_q - AW'(1);
    assign maj      = (op[0] & op[1]) | (op[0] & op[2]) | (op[1] & op[2]);
    assign sel_bad  = {1'b0, sel_q} >= out_lim;
    assign sel_val  = (sel_bad ? 1'b0 : sig[sel_q]) ^ inv_q;

    always_comb begin
        bad = '0;
        op  = '0;
        for (int k = 0; k < 3; k++) begin
            bad[k] = {1'b0, ent[(2-k)*E +: SW]} >= gate_lim;
            op[k]  = (bad[k] ? 1'b0 : sig[ent[(2-k)*E +: SW]]) ^ ent[(2-k)*E + SW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (num_eff != '0) ? EVAL : DONE;
            EVAL:    if (last) state_d = DONE;
            DONE:    if (ov_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        cfg_ready = state_q == IDLE;
        out_valid = ov_q;
        y         = y_q;
        out_err   = err_q;
    end

    always_comb begin
        tbl_d = tbl_q;
        num_d = num_q;
        inv_d = inv_q;
        sel_d = sel_q;
        x_d   = x_q;
        gv_d  = gv_q;
        g_d   = g_q;
        y_d   = y_q;
        err_d = err_q;
        ov_d  = ov_q;
        if (wr_gate) tbl_d[cfg_addr[GW-1:0]] = cfg_data;
        if (wr_ctrl) begin
            num_d = num_wr;
            inv_d = cfg_data[SW];
            sel_d = cfg_data[SW-1:0];
        end
        if (state_q == IDLE && in_valid) begin
            x_d   = x;
            gv_d  = '0;
            g_d   = '0;
            err_d = 1'b0;
        end
        if (state_q == EVAL) begin
            gv_d[g_q] = maj;
            err_d     = err_q | (|bad);
            g_d       = g_q + GW'(1);
        end
        // First DONE cycle registers the result; out_valid rises the cycle after.
        if (state_q == DONE && !ov_q) begin
            y_d   = sel_val;
            err_d = err_q | sel_bad;
            ov_d  = 1'b1;
        end
        if (state_q == DONE && ov_q && out_ready) ov_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_q <= '{default: '0};
            num_q <= '0;
            inv_q <= 1'b0;
            sel_q <= '0;
            x_q   <= '0;
            gv_q  <= '0;
            g_q   <= '0;
            y_q   <= 1'b0;
            err_q <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            tbl_q <= tbl_d;
            num_q <= num_d;
            inv_q <= inv_d;
            sel_q <= sel_d;
            x_q   <= x_d;
            gv_q  <= gv_d;
            g_q   <= g_d;
            y_q   <= y_d;
            err_q <= err_d;
            ov_q  <= ov_d;
        end
    end
endmodule

// File: tb/tb_mig_seq_eval.sv
// tb_mig_seq_eval: scoreboard bench with a behavioural MIG reference model and random programs.
module tb_mig_seq_eval;
    localparam int NI = 4;
    localparam int MG = 8;
    localparam int SW = 4;
    localparam int E  = 5;
    localparam int DW = 15;
    localparam int AW = 4;

    logic          clk = 1'b0, rst = 1'b1, cfg_we = 1'b0, in_valid = 1'b0, out_ready;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic [NI-1:0] x = '0;
    logic          cfg_ready, in_ready, out_valid, y, out_err;

    mig_seq_eval dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic y; logic e; int t;} exp_t;
    exp_t q[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   m_inv[MG][3], m_idx[MG][3];
    int   m_num, m_oinv, m_osel;
    bit   rnd_rdy = 0, force_rdy = 1, seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int g = 0; g < MG; g++)
            for (int k = 0; k < 3; k++) begin
                m_inv[g][k] = 0;
                m_idx[g][k] = 0;
            end
        m_num = 0; m_oinv = 0; m_osel = 0;
    endfunction

    function automatic void model_apply(input int addr, input logic [DW-1:0] d);
        int n;
        if (addr < MG) begin
            for (int k = 0; k < 3; k++) begin
                m_idx[addr][k] = int'((d >> ((2-k)*E)) & 15);
                m_inv[addr][k] = int'((d >> ((2-k)*E + SW)) & 1);
            end
        end else if (addr == MG) begin
            n      = int'((d >> E) & 15);
            m_num  = n > MG ? MG : n;
            m_oinv = int'((d >> SW) & 1);
            m_osel = int'(d & 15);
        end
    endfunction

    // Walks the netlist as a list of majority votes over an integer signal table.
    function automatic exp_t model(input logic [NI-1:0] xv);
        int   s[13];
        int   v[3];
        exp_t r;
        r.e = 0;
        foreach (s[i]) s[i] = 0;
        for (int i = 0; i < NI; i++) s[i+1] = int'(xv[i]);
        for (int g = 0; g < m_num; g++) begin
            for (int k = 0; k < 3; k++) begin
                if (m_idx[g][k] >= NI + 1 + g) begin
                    v[k] = 0;
                    r.e  = 1;
                end else v[k] = s[m_idx[g][k]];
                v[k] = v[k] ^ m_inv[g][k];
            end
            s[NI+1+g] = (v[0] + v[1] + v[2] >= 2) ? 1 : 0;
        end
        if (m_osel >= NI + 1 + m_num) begin
            r.e = 1;
            r.y = 1'(m_oinv);
        end else r.y = 1'(s[m_osel] ^ m_oinv);
        r.t = m_num + 1;
        return r;
    endfunction

    function automatic logic [DW-1:0] gd(input int ia, input int sa, input int ib, input int sb,
                                         input int ic, input int sc);
        return {1'(ia), 4'(sa), 1'(ib), 4'(sb), 1'(ic), 4'(sc)};
    endfunction

    function automatic logic [DW-1:0] cd(input int n, input int inv, input int sel);
        return {6'd0, 4'(n), 1'(inv), 4'(sel)};
    endfunction

    task automatic cfg_wr(input int addr, input logic [DW-1:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = d;
        if (cfg_ready) model_apply(addr, d);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic send(input logic [NI-1:0] xv, input bit wc, input logic [DW-1:0] c);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", int'(in_ready), 1);
            return;
        end
        in_valid = 1'b1; x = xv;
        if (wc) begin
            cfg_we = 1'b1; cfg_addr = AW'(MG); cfg_data = c;
            model_apply(MG, c);
        end
        @(posedge clk);
        #1;
        e = model(xv);
        e.t = cyc + e.t;
        q.push_back(e);
        in_valid = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial forever begin
        @(negedge clk);
        out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) seen = 0;
        else if (out_valid && !seen) begin
            seen = 1;
            if (q.size() == 0) chk("unexpected_out_valid", int'(out_valid), 0);
            else begin
                e = q.pop_front();
                chk("y", int'(y), int'(e.y));
                chk("out_err", int'(out_err), int'(e.e));
                chk("latency_cycle", cyc, e.t);
            end
        end else if (!out_valid) seen = 0;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic y0;
        int   n, sel;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_out_err", int'(out_err), 0);

        send(4'b1111, 0, '0);
        drain();

        cfg_wr(0, gd(0, 1, 0, 2, 0, 3));
        cfg_wr(MG, cd(1, 0, 5));
        send(4'b0011, 0, '0);
        send(4'b0001, 0, '0);
        drain();

        cfg_wr(0, gd(0, 1, 0, 2, 0, 0));
        cfg_wr(1, gd(1, 5, 0, 3, 1, 0));
        cfg_wr(MG, cd(2, 1, 6));
        for (int i = 0; i < 16; i++) send(4'(i), 0, '0);
        drain();

        cfg_wr(0, gd(0, 6, 0, 1, 0, 2));
        send(4'b0110, 0, '0);
        send(4'b1111, 0, '0);
        cfg_wr(0, gd(0, 1, 0, 2, 0, 3));
        cfg_wr(MG, cd(2, 0, 14));
        send(4'b0111, 0, '0);
        cfg_wr(MG, cd(2, 0, 6));
        send(4'b0111, 0, '0);
        drain();

        force_rdy = 0;
        send(4'b0101, 0, '0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached_done", int'(out_valid), 1);
        y0 = y;
        for (int i = 0; i < 5; i++) begin
            cfg_wr(MG, cd(1, 1, 0));
            chk("hold_y", int'(y), int'(y0));
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_cfg_ready", int'(cfg_ready), 0);
        end
        force_rdy = 1;
        send(4'b1010, 0, '0);
        drain();

        send(4'b0011, 1, cd(15, 0, 12));
        send(4'b1100, 1, cd(0, 1, 3));
        drain();

        for (int g = 0; g < MG; g++)
            cfg_wr(g, gd($urandom_range(0, 1), $urandom_range(0, NI + g), $urandom_range(0, 1),
                        $urandom_range(0, NI + g), $urandom_range(0, 1), $urandom_range(0, NI + g)));
        cfg_wr(MG, cd(8, 0, 12));
        send(4'b1011, 0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_in_ready", int'(in_ready), 1);
        send(4'b1011, 0, '0);
        drain();

        rnd_rdy = 1;
        for (int p = 0; p < 25; p++) begin
            for (int g = 0; g < MG; g++) begin
                int s[3];
                for (int k = 0; k < 3; k++)
                    s[k] = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NI + g);
                cfg_wr(g, gd($urandom_range(0, 1), s[0], $urandom_range(0, 1), s[1],
                            $urandom_range(0, 1), s[2]));
            end
            n   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(1, MG);
            sel = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15)
                                              : $urandom_range(0, NI + (n > MG ? MG : n));
            cfg_wr(MG, cd(n, $urandom_range(0, 1), sel));
            for (int v = 0; v < 4; v++) send(4'($urandom_range(0, 15)), 0, '0);
        end
        drain();
        rnd_rdy = 0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
